// File: rtl/oled_cmd_seq.sv
// SSD1306-class command sequencer: replays the power-up init or power-down
// command list through the SPI byte master using a request/done handshake.
module oled_cmd_seq #(
  parameter logic [7:0]  CONTRAST    = 8'hCF,
  parameter logic [19:0] POWERUP_DLY = 20'd100000,
  parameter logic [19:0] OFF_DLY     = 20'd100000,
  parameter logic [15:0] TIMEOUT     = 16'd4096,
  parameter bit          AUTO_INIT   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic       send_done,
  output logic       spi_send,
  output logic [7:0] spi_data,
  output logic       dc,
  output logic       busy,
  output logic       init_done,
  output logic       off_done,
  output logic       err
);

  localparam logic [19:0] DLY_MAX = (POWERUP_DLY > OFF_DLY) ? POWERUP_DLY : OFF_DLY;
  localparam int unsigned DW      = (DLY_MAX > 20'd1) ? $clog2(DLY_MAX) : 1;
  localparam int unsigned TW      = (TIMEOUT > 16'd1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned IW      = 4;

  localparam logic [DW-1:0] PU_LAST  = DW'(POWERUP_DLY - 20'd1);
  localparam logic [DW-1:0] OFF_LAST = DW'(OFF_DLY - 20'd1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 16'd1);
  localparam logic [IW-1:0] INIT_LAST = IW'(10);
  localparam logic [IW-1:0] OFF_IDX_LAST = IW'(2);

  typedef enum logic [2:0] {IDLE, DLY, SEND, GAP, DONE, ERR} state_t;

  state_t        state, state_n;
  logic          mode_q, mode_n;
  logic [IW-1:0] idx, idx_n;
  logic [DW-1:0] dly_cnt, dly_n;
  logic [TW-1:0] to_cnt, to_n;
  logic [7:0]    spi_data_n;
  logic          spi_send_n, busy_n, init_n, off_n, err_n;
  logic          auto_pend, auto_n;
  logic          go, go_mode;

  // Command tables; power-down entries beyond index 2 are never addressed
  function automatic logic [7:0] tbl(input logic m, input logic [IW-1:0] i);
    logic [7:0] b;
    b = 8'h00;
    if (!m) begin
      case (i)
        4'd0:    b = 8'hAE;
        4'd1:    b = 8'hD5;
        4'd2:    b = 8'h80;
        4'd3:    b = 8'h8D;
        4'd4:    b = 8'h14;
        4'd5:    b = 8'h81;
        4'd6:    b = CONTRAST;
        4'd7:    b = 8'hD9;
        4'd8:    b = 8'hF1;
        4'd9:    b = 8'hA0;
        4'd10:   b = 8'hAF;
        default: b = 8'h00;
      endcase
    end else begin
      case (i)
        4'd0:    b = 8'hAE;
        4'd1:    b = 8'h8D;
        4'd2:    b = 8'h10;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  assign dc = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      idx       <= '0;
      dly_cnt   <= '0;
      to_cnt    <= '0;
      spi_send  <= 1'b0;
      spi_data  <= 8'h00;
      busy      <= 1'b0;
      init_done <= 1'b0;
      off_done  <= 1'b0;
      err       <= 1'b0;
      auto_pend <= AUTO_INIT;
    end else begin
      state     <= state_n;
      mode_q    <= mode_n;
      idx       <= idx_n;
      dly_cnt   <= dly_n;
      to_cnt    <= to_n;
      spi_send  <= spi_send_n;
      spi_data  <= spi_data_n;
      busy      <= busy_n;
      init_done <= init_n;
      off_done  <= off_n;
      err       <= err_n;
      auto_pend <= auto_n;
    end
  end

  // Next state; every output is registered from its *_n value
  always_comb begin
    state_n    = state;
    mode_n     = mode_q;
    idx_n      = idx;
    dly_n      = dly_cnt;
    to_n       = to_cnt;
    spi_data_n = spi_data;
    init_n     = init_done;
    off_n      = off_done;
    err_n      = err;
    auto_n     = 1'b0;
    go         = (start || auto_pend);
    go_mode    = auto_pend ? 1'b0 : mode;

    case (state)
      IDLE, DONE, ERR: begin
        if (go) begin
          mode_n = go_mode;
          idx_n  = '0;
          dly_n  = '0;
          to_n   = '0;
          init_n = 1'b0;
          off_n  = 1'b0;
          err_n  = 1'b0;
          if (!go_mode && POWERUP_DLY != 20'd0) begin
            state_n = DLY;
          end else begin
            state_n    = SEND;
            spi_data_n = tbl(go_mode, '0);
          end
        end
      end
      DLY: begin
        if (dly_cnt == (mode_q ? OFF_LAST : PU_LAST)) begin
          dly_n = '0;
          if (!mode_q) begin
            state_n    = SEND;
            to_n       = '0;
            spi_data_n = tbl(1'b0, idx);
          end else begin
            state_n = DONE;
            off_n   = 1'b1;
          end
        end else begin
          dly_n = dly_cnt + DW'(1);
        end
      end
      SEND: begin
        if (send_done) begin
          if (idx == (mode_q ? OFF_IDX_LAST : INIT_LAST)) begin
            if (!mode_q) begin
              state_n = DONE;
              init_n  = 1'b1;
            end else if (OFF_DLY != 20'd0) begin
              state_n = DLY;
              dly_n   = '0;
            end else begin
              state_n = DONE;
              off_n   = 1'b1;
            end
          end else begin
            idx_n   = idx + IW'(1);
            state_n = GAP;
          end
        end else if (TIMEOUT != 16'd0 && to_cnt == TO_LAST) begin
          state_n = ERR;
          err_n   = 1'b1;
        end else begin
          to_n = to_cnt + TW'(1);
        end
      end
      GAP: begin
        state_n    = SEND;
        to_n       = '0;
        spi_data_n = tbl(mode_q, idx);
      end
      default: state_n = IDLE;
    endcase

    spi_send_n = (state_n == SEND);
    busy_n     = (state_n == DLY) || (state_n == SEND) || (state_n == GAP);
  end

endmodule

// File: tb/tb_oled_cmd_seq.sv
// Scoreboard bench for oled_cmd_seq: one delayed auto-init instance and one
// zero-delay manual instance, each driven by a simple SPI done-pulse model.
module tb_oled_cmd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       a_start = 1'b0, a_mode = 1'b0, a_done = 1'b0;
  logic       a_send, a_dc, a_busy, a_init, a_off, a_err;
  logic [7:0] a_data;
  logic       z_start = 1'b0, z_mode = 1'b0, z_done = 1'b0;
  logic       z_send, z_dc, z_busy, z_init, z_off, z_err;
  logic [7:0] z_data;

  oled_cmd_seq #(.CONTRAST(8'hCF), .POWERUP_DLY(20'd4), .OFF_DLY(20'd5),
                 .TIMEOUT(16'd8), .AUTO_INIT(1'b1)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .mode(a_mode), .send_done(a_done),
    .spi_send(a_send), .spi_data(a_data), .dc(a_dc), .busy(a_busy),
    .init_done(a_init), .off_done(a_off), .err(a_err));

  oled_cmd_seq #(.CONTRAST(8'hCF), .POWERUP_DLY(20'd0), .OFF_DLY(20'd0),
                 .TIMEOUT(16'd8), .AUTO_INIT(1'b0)) u_z (
    .clk(clk), .reset(reset), .start(z_start), .mode(z_mode), .send_done(z_done),
    .spi_send(z_send), .spi_data(z_data), .dc(z_dc), .busy(z_busy),
    .init_done(z_init), .off_done(z_off), .err(z_err));

  logic [7:0] init_b [11] = '{8'hAE, 8'hD5, 8'h80, 8'h8D, 8'h14, 8'h81,
                              8'hCF, 8'hD9, 8'hF1, 8'hA0, 8'hAF};
  logic [7:0] off_b  [3]  = '{8'hAE, 8'h8D, 8'h10};
  logic [7:0] exp_a [$];
  logic [7:0] exp_z [$];

  int n_total = 0, n_bad = 0, cyc = 0, n = 0;
  int a_cyc = 0, a_nb = 0, a_hang = 0, a_rise_cyc = 0, a_ld_cyc = 0;
  int z_cyc = 0, z_ld_cyc = 0;
  bit a_spur = 1'b0, a_send_q = 1'b0, z_send_q = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_a(input bit md);
    if (md) foreach (off_b[i]) exp_a.push_back(off_b[i]);
    else    foreach (init_b[i]) exp_a.push_back(init_b[i]);
  endtask

  task automatic push_z(input bit md);
    if (md) foreach (off_b[i]) exp_z.push_back(off_b[i]);
    else    foreach (init_b[i]) exp_z.push_back(init_b[i]);
  endtask

  // Counts busy cycles from the current one; optionally pokes start mid-run
  task automatic count_busy(output int cnt, input bit poke);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (!a_busy) break;
      cnt++;
      a_start = poke && (i == 10 || i == 30);
      a_mode  = a_start;
      @(negedge clk);
    end
    a_start = 1'b0;
    a_mode  = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SPI model for u_a: done on 3rd SEND cycle, optional hang and spurious done
  initial forever begin
    @(negedge clk);
    if (!a_busy) a_nb = 0;
    if (a_send) begin
      if (a_cyc == 0) begin
        a_nb++;
        a_rise_cyc = cyc;
      end
      a_cyc++;
      a_done = (a_cyc == 3) && (a_nb != a_hang);
      if (a_done) a_ld_cyc = cyc;
    end else begin
      a_cyc  = 0;
      a_done = a_spur;
    end
  end

  initial forever begin
    @(negedge clk);
    if (z_send) begin
      z_cyc++;
      z_done = (z_cyc == 3);
      if (z_done) z_ld_cyc = cyc;
    end else begin
      z_cyc  = 0;
      z_done = 1'b0;
    end
  end

  // Byte monitors: each new request is popped against the expected queue
  initial forever begin
    @(negedge clk);
    if (a_send && !a_send_q) begin
      if (exp_a.size() == 0) chk("a_extra_byte", 32'(a_data), 32'hFFFF_FFFF);
      else chk("a_byte", 32'(a_data), 32'(exp_a.pop_front()));
      chk("a_dc", 32'(a_dc), 32'd0);
    end
    a_send_q = a_send;
    if (z_send && !z_send_q) begin
      if (exp_z.size() == 0) chk("z_extra_byte", 32'(z_data), 32'hFFFF_FFFF);
      else chk("z_byte", 32'(z_data), 32'(exp_z.pop_front()));
      chk("z_dc", 32'(z_dc), 32'd0);
    end
    z_send_q = z_send;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with start asserted: reset must win
    a_start = 1'b1;
    z_start = 1'b1;
    repeat (3) @(negedge clk);
    chk("a_reset_outs", 32'({a_send, a_busy, a_init, a_off, a_err, a_dc, a_data}), 32'd0);
    chk("z_reset_outs", 32'({z_send, z_busy, z_init, z_off, z_err, z_dc, z_data}), 32'd0);
    a_start = 1'b0;
    z_start = 1'b0;

    // Auto-init with spurious done pulses and ignored start requests
    push_a(1'b0);
    a_spur = 1'b1;
    reset  = 1'b0;
    @(negedge clk);
    chk("a_autostart_busy", 32'(a_busy), 32'd1);
    count_busy(n, 1'b1);
    chk("a_init_busy_len", 32'(n), 32'd47);
    chk("a_init_done", 32'(a_init), 32'd1);
    chk("a_init_q_empty", 32'(exp_a.size()), 32'd0);
    chk("z_no_activity", 32'({z_busy, z_send, z_init, z_off}), 32'd0);

    // Power-down from DONE
    push_a(1'b1);
    a_start = 1'b1;
    a_mode  = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_mode  = 1'b0;
    chk("pd_init_cleared", 32'({a_init, a_busy}), 32'b01);
    for (int i = 0; i < 200 && !a_off; i++) @(negedge clk);
    chk("pd_off_done", 32'({a_off, a_busy, a_init}), 32'b100);
    chk("pd_off_latency", 32'(cyc - a_ld_cyc), 32'd6);
    chk("pd_q_empty", 32'(exp_a.size()), 32'd0);

    // Timeout: second byte never answered
    a_hang = 2;
    exp_a.push_back(8'hAE);
    exp_a.push_back(8'hD5);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 200 && !a_err; i++) @(negedge clk);
    chk("to_err", 32'(a_err), 32'd1);
    chk("to_send_cycles", 32'(cyc - a_rise_cyc), 32'd8);
    chk("to_outs", 32'({a_send, a_busy, a_init, a_off}), 32'd0);
    chk("to_q_empty", 32'(exp_a.size()), 32'd0);

    // Restart from ERR clears err and replays from AE
    a_hang = 0;
    push_a(1'b0);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    chk("to_restart", 32'({a_err, a_busy}), 32'b01);
    for (int i = 0; i < 200 && !a_init; i++) @(negedge clk);
    chk("to_restart_done", 32'(a_init), 32'd1);
    chk("to_restart_q_empty", 32'(exp_a.size()), 32'd0);

    // Reset during the fifth byte, together with start
    push_a(1'b0);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 200 && !(a_nb == 5 && a_cyc == 2); i++) @(negedge clk);
    chk("rst_reached_byte5", 32'(a_nb), 32'd5);
    reset   = 1'b1;
    a_start = 1'b1;
    exp_a.delete();
    push_a(1'b0);
    @(negedge clk);
    chk("rst_mid_outs", 32'({a_send, a_busy, a_init, a_off, a_err, a_data}), 32'd0);
    a_start = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    count_busy(n, 1'b0);
    chk("rst_rerun_busy_len", 32'(n), 32'd47);
    chk("rst_rerun_done", 32'(a_init), 32'd1);
    chk("rst_rerun_q_empty", 32'(exp_a.size()), 32'd0);

    // Zero-delay instance: manual start, immediate SEND, immediate off_done
    chk("z_still_idle", 32'({z_busy, z_send, z_init}), 32'd0);
    push_z(1'b0);
    z_start = 1'b1;
    @(negedge clk);
    z_start = 1'b0;
    chk("z_send_next", 32'({z_send, z_busy}), 32'b11);
    for (int i = 0; i < 200 && !z_init; i++) @(negedge clk);
    chk("z_init_done", 32'(z_init), 32'd1);
    chk("z_init_q_empty", 32'(exp_z.size()), 32'd0);
    push_z(1'b1);
    z_start = 1'b1;
    z_mode  = 1'b1;
    @(negedge clk);
    z_start = 1'b0;
    z_mode  = 1'b0;
    chk("z_pd_send_next", 32'({z_send, z_init}), 32'b10);
    for (int i = 0; i < 200 && !z_off; i++) @(negedge clk);
    chk("z_off_done", 32'({z_off, z_busy, z_err}), 32'b100);
    chk("z_off_latency", 32'(cyc - z_ld_cyc), 32'd1);
    chk("z_pd_q_empty", 32'(exp_z.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/oled_cmd_seq.md
# oled_cmd_seq

Parametrised OLED controller command sequencer: replays a fixed SSD1306-class command list through the SPI byte master using a request/done handshake. Supports two selectable sequences: power-up init and power-down. Supports a programmable power-rail delay, an optional auto-start after reset, and a send_done timeout with sticky error. Sits between the top-level display controller and the SPI master, ahead of the frame-update logic, which waits on `init_done`.

## Interface
- `CONTRAST`, 8'hCF, data byte following the 0x81 contrast command.
- `POWERUP_DLY`, 20'd100000, cycles waited before the first init byte; 0 = no wait.
- `OFF_DLY`, 20'd100000, cycles waited after the last power-down byte; 0 = no wait.
- `TIMEOUT`, 16'd4096, max cycles in SEND without `send_done`; 0 = disabled.
- `AUTO_INIT`, 1, 1 = start init automatically after reset.
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: sequence request, sampled only when not busy.
- `mode` in 1: 0 = init sequence, 1 = power-down sequence; sampled with `start`.
- `send_done` in 1: one-cycle pulse from the SPI master, byte accepted.
- `spi_send` out 1: byte request level.
- `spi_data` out 8: command byte, stable while `spi_send` = 1.
- `dc` out 1: data/command select, constant 0 (all entries are commands).
- `busy` out 1: sequence in progress.
- `init_done` out 1: level, init sequence completed.
- `off_done` out 1: level, power-down sequence completed.
- `err` out 1: sticky, timeout occurred.

## Operation
- Init table, indices 0–10: AE, D5, 80, 8D, 14, 81, CONTRAST, D9, F1, A0, AF.
- Power-down table, indices 0–2: AE, 8D, 10.
- States:
  - IDLE, DLY, SEND, GAP, DONE, ERR.
  - `busy` = 1 in DLY/SEND/GAP only.
- Start condition:
  - Asserted when `start` = 1 in IDLE/DONE/ERR, or when AUTO_INIT = 1 on the first post-reset cycle (forced mode 0).
  - On start, latch mode, index = 0, and clear `init_done`, `off_done` and `err`.
- Start transition:
  - Init with POWERUP_DLY > 0 → DLY; otherwise → SEND.
  - Power-down always → SEND.
- DLY:
  - Counter runs POWERUP_DLY (init) or OFF_DLY (power-down) cycles.
  - Init: then → SEND.
  - Power-down: then → DONE, setting `off_done`.
- SEND:
  - `spi_send` = 1; `spi_data` = table[index].
  - On `send_done` = 1:
    - If index is not last: index++ → GAP.
    - Last init byte: → DONE, set `init_done`.
    - Last power-down byte: → DLY if OFF_DLY > 0, else → DONE, set `off_done`.
- GAP: `spi_send` = 0 for exactly one cycle → SEND.
- Timeout:
  - Timeout counter clears on SEND entry and counts while in SEND.
  - On reaching TIMEOUT with TIMEOUT ≠ 0: → ERR, set `err`, `spi_send` = 0, `busy` = 0; done flags stay 0.
- `send_done` outside SEND is ignored.
- `start` while busy is ignored; `mode` is not re-sampled.
- Counters are sized to their parameters. DLY counts 0..D−1 and exits on D−1, with no wrap.

## Timing
- Reset:
  - All outputs 0, `spi_data` = 8'h00, state IDLE, index 0.
  - Reset wins over a simultaneous `start`.
  - Reset mid-sequence aborts immediately. `spi_send` drops on the edge; AUTO_INIT re-runs.
- All outputs derive from registers only; there is no combinational input→output path.
- Start accepted at edge t: `busy` = 1 and the state becomes DLY/SEND from cycle t+1.
- DLY of D lasts exactly D cycles.
- Byte handshake:
  - `spi_send` rises on SEND entry.
  - `send_done` sampled at edge e: `spi_send` = 0 at e+1 (GAP), next byte requested at e+2.
- Last byte:
  - `send_done` at edge e: `init_done` = 1 and `busy` = 0 from e+1.
  - Power-down with OFF_DLY = D: `off_done` = 1 at e+1+D.
- Init total, POWERUP_DLY = D, SPI latency L cycles per byte: `init_done` rises D + 11L + 10 cycles after the first busy cycle.

## Test plan
- Auto-init:
  - Stimulus: AUTO_INIT = 1, POWERUP_DLY = 4, SPI model pulses `send_done` on the 3rd SEND cycle.
  - Required: bytes AE, D5, 80, 8D, 14, 81, CF, D9, F1, A0, AF in order with `dc` = 0. `busy` high 4 + 33 + 10 = 47 cycles, then `init_done` = 1.
- Power-down:
  - Stimulus: `start` = 1, `mode` = 1 while DONE, OFF_DLY = 5.
  - Required: `init_done` clears next cycle; bytes AE, 8D, 10 sent; `off_done` = 1 exactly 6 cycles after the last `send_done`.
- Timeout:
  - Stimulus: TIMEOUT = 8, SPI model never answers byte 2.
  - Required: after 8 SEND cycles, `err` = 1, `spi_send` = 0, `busy` = 0, `init_done` = 0. A following `start` clears `err` and restarts at AE.
- Ignored inputs:
  - Stimulus: `start` pulses mid-sequence; a spurious `send_done` during GAP/DLY.
  - Required: sequence order and count are unchanged, and no byte is skipped.
- Reset mid-sequence:
  - Stimulus: `reset` asserted during byte 5 SEND, together with `start`.
  - Required: all outputs 0 next cycle. After release, init restarts from AE following POWERUP_DLY.
- Zero-delay config:
  - Stimulus: POWERUP_DLY = 0, OFF_DLY = 0, AUTO_INIT = 0.
  - Required: no activity until `start`. SEND is entered the cycle after `start`, and `off_done` rises the cycle after the last `send_done`.
